// File: rtl/row_event_requester.sv
// Requester side of the event-readout row arbiter: collects per-row event pulses into
// frozen arbitration groups and turns each accepted grant into a row/timestamp output event.
module row_event_requester #(
    parameter int Lvl_ROWS    = 2,
    parameter int Lvl_ROW_ADD = 1,
    parameter int TS_WIDTH    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [Lvl_ROWS-1:0]    evt_i,
    input  logic [Lvl_ROWS-1:0]    gnt_i,
    input  logic                   grp_release_i,
    input  logic                   out_ready_i,
    output logic [Lvl_ROWS-1:0]    req_o,
    output logic                   arb_enable_o,
    output logic                   arb_clear_o,
    output logic                   evt_valid_o,
    output logic [Lvl_ROW_ADD-1:0] evt_row_o,
    output logic [TS_WIDTH-1:0]    evt_ts_o,
    output logic                   overflow_o,
    output logic                   protocol_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_REL,
        S_CLEAR
    } state_t;

    state_t                 state_q, state_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [TS_WIDTH-1:0]    grp_ts_q, grp_ts_d;
    logic [TS_WIDTH-1:0]    evt_ts_q, evt_ts_d;
    logic [Lvl_ROWS-1:0]    pending_q, pending_d;
    logic [Lvl_ROWS-1:0]    group_q, group_d;
    logic [Lvl_ROWS-1:0]    grp_req_q, grp_req_d;
    logic [Lvl_ROW_ADD-1:0] evt_row_q, evt_row_d;
    logic                   evt_valid_q, evt_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   perr_q, perr_d;

    logic                   out_stall;
    logic                   gnt_onehot;
    logic                   gnt_accept;
    logic                   arb_enable;
    logic [Lvl_ROWS-1:0]    new_group;

    function automatic logic is_onehot(input logic [Lvl_ROWS-1:0] v);
        return (v != '0) && ((v & (v - Lvl_ROWS'(1))) == '0);
    endfunction

    function automatic logic [Lvl_ROW_ADD-1:0] onehot_index(input logic [Lvl_ROWS-1:0] v);
        logic [Lvl_ROW_ADD-1:0] idx;
        idx = '0;
        for (int i = 0; i < Lvl_ROWS; i++) begin
            if (v[i]) begin
                idx = Lvl_ROW_ADD'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        out_stall   = evt_valid_q && !out_ready_i;
        gnt_onehot  = is_onehot(gnt_i);
        // A held grant is only taken once the output slot can absorb it.
        gnt_accept  = (state_q == S_ARB) && gnt_onehot && ((gnt_i & group_q) != '0) && !out_stall;
        new_group   = pending_q | evt_i;

        state_d     = state_q;
        ts_d        = ts_q + TS_WIDTH'(1);
        pending_d   = pending_q | evt_i;
        group_d     = group_q;
        grp_req_d   = grp_req_q;
        grp_ts_d    = grp_ts_q;
        evt_valid_d = evt_valid_q;
        evt_row_d   = evt_row_q;
        evt_ts_d    = evt_ts_q;
        overflow_d  = (evt_i & pending_q) != '0;
        perr_d      = perr_q;
        arb_enable  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Same-cycle events join the group being frozen rather than waiting a round.
                if (new_group != '0) begin
                    group_d   = new_group;
                    grp_req_d = new_group;
                    pending_d = '0;
                    grp_ts_d  = ts_q;
                    state_d   = S_ARB;
                end
            end
            S_ARB: begin
                arb_enable = !out_stall;
                // grp_req_q remembers the whole frozen group, so re-presented grants
                // for rows already served are silently dropped instead of flagged.
                if (gnt_i != '0) begin
                    if (!gnt_onehot || ((gnt_i & grp_req_q) == '0)) begin
                        perr_d = 1'b1;
                    end
                end
                if (gnt_accept) begin
                    group_d = group_q & ~gnt_i;
                end
                if ((group_q == '0) && !out_stall) begin
                    state_d = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                arb_enable = 1'b1;
                if (grp_release_i) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (gnt_accept) begin
            evt_valid_d = 1'b1;
            evt_row_d   = onehot_index(gnt_i);
            evt_ts_d    = grp_ts_q;
        end else if (out_ready_i) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            grp_ts_q    <= '0;
            evt_ts_q    <= '0;
            pending_q   <= '0;
            group_q     <= '0;
            grp_req_q   <= '0;
            evt_row_q   <= '0;
            evt_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            grp_ts_q    <= grp_ts_d;
            evt_ts_q    <= evt_ts_d;
            pending_q   <= pending_d;
            group_q     <= group_d;
            grp_req_q   <= grp_req_d;
            evt_row_q   <= evt_row_d;
            evt_valid_q <= evt_valid_d;
            overflow_q  <= overflow_d;
            perr_q      <= perr_d;
        end
    end

    assign req_o          = group_q;
    assign arb_enable_o   = arb_enable;
    assign arb_clear_o    = (state_q == S_CLEAR);
    assign evt_valid_o    = evt_valid_q;
    assign evt_row_o      = evt_row_q;
    assign evt_ts_o       = evt_ts_q;
    assign overflow_o     = overflow_q;
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_row_event_requester.sv
// Bench for row_event_requester: behavioural row arbiter, event scoreboard, group vector table
// and hand-written overflow / duplicate-grant / protocol-error / reset sequences.
module tb_row_event_requester;

    localparam int ROWS = 4;
    localparam int RA   = 2;
    localparam int TSW  = 16;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_i = 1'b1;
    logic [ROWS-1:0] evt = '0;
    logic [ROWS-1:0] gnt;
    logic            grp_release;
    logic            ready = 1'b1;
    logic [ROWS-1:0] req_o;
    logic            arb_enable_o, arb_clear_o, evt_valid_o, overflow_o, protocol_err_o;
    logic [RA-1:0]   evt_row_o;
    logic [TSW-1:0]  evt_ts_o;

    row_event_requester #(.Lvl_ROWS(ROWS), .Lvl_ROW_ADD(RA), .TS_WIDTH(TSW)) dut (
        .clk_i(clk), .reset_i(reset_i), .evt_i(evt), .gnt_i(gnt),
        .grp_release_i(grp_release), .out_ready_i(ready), .req_o(req_o),
        .arb_enable_o(arb_enable_o), .arb_clear_o(arb_clear_o), .evt_valid_o(evt_valid_o),
        .evt_row_o(evt_row_o), .evt_ts_o(evt_ts_o), .overflow_o(overflow_o),
        .protocol_err_o(protocol_err_o)
    );

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Behavioural registered arbiter: fixed low-row priority, each row granted once per group.
    logic [ROWS-1:0] gnt_m = '0, done_m = '0, force_gnt = '0;
    logic            force_en = 1'b0, arb_hold = 1'b0;
    assign gnt         = force_en ? force_gnt : gnt_m;
    assign grp_release = ((req_o & ~done_m) == '0);

    function automatic logic [ROWS-1:0] lowest(input logic [ROWS-1:0] v);
        logic [ROWS-1:0] r;
        r = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) r = ROWS'(1) << i;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset_i || arb_clear_o) begin
            gnt_m  <= '0;
            done_m <= '0;
        end else if (arb_enable_o && !arb_hold) begin
            gnt_m  <= lowest(req_o & ~done_m);
            done_m <= done_m | lowest(req_o & ~done_m);
        end
    end

    // Reference time base: cycles since the last reset edge.
    logic [TSW-1:0] cyc = '0;
    always @(posedge clk) cyc <= reset_i ? '0 : cyc + 16'd1;

    typedef struct packed {
        logic [RA-1:0]  row;
        logic [TSW-1:0] ts;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset_i && evt_valid_o && ready) begin
            hs_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got row %0d ts %0d, required no event", evt_row_o, evt_ts_o);
            end else begin
                mon_e = q.pop_front();
                chk("evt_row", 32'(evt_row_o), 32'(mon_e.row));
                chk("evt_ts", 32'(evt_ts_o), 32'(mon_e.ts));
            end
        end
    end

    typedef struct {
        logic [ROWS-1:0] evt;
        int              stall;
        logic [ROWS-1:0] exp_req;
        int              n_events;
    } vec_t;
    vec_t vecs[5];

    task automatic wait_group_end(input string nm);
        int clears;
        bit done;
        clears = 0;
        done   = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(posedge clk); #1;
            if (arb_clear_o) clears++;
            else if (clears > 0) done = 1;
        end
        chk({nm, "_done"}, 32'(done), 32'(1));
        chk({nm, "_clear_pulses"}, 32'(clears), 32'(1));
    endtask

    task automatic run_group(input vec_t v);
        int            hs0;
        bit            seen;
        logic [RA-1:0] held_row;
        hs0 = hs_cnt;
        for (int i = 0; i < ROWS; i++) begin
            if (v.evt[i]) q.push_back('{row: RA'(i), ts: cyc});
        end
        evt = v.evt;
        @(posedge clk); #1;
        evt = '0;
        chk("req_capture", 32'(req_o), 32'(v.exp_req));
        chk("arb_enable_first", 32'(arb_enable_o), 32'(1));
        if (v.stall > 0) begin
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(posedge clk); #1;
                if (evt_valid_o) seen = 1;
            end
            chk("stall_valid_seen", 32'(seen), 32'(1));
            ready    = 1'b0;
            held_row = evt_row_o;
            for (int k = 0; k < v.stall; k++) begin
                @(negedge clk);
                chk("stall_arb_enable", 32'(arb_enable_o), 32'(0));
                chk("stall_valid", 32'(evt_valid_o), 32'(1));
                chk("stall_row_held", 32'(evt_row_o), 32'(held_row));
                @(posedge clk); #1;
            end
            ready = 1'b1;
        end
        wait_group_end("group");
        chk("group_event_count", 32'(hs_cnt - hs0), 32'(v.n_events));
        chk("group_queue_empty", 32'(q.size()), 32'(0));
        chk("idle_req", 32'(req_o), 32'(0));
        chk("idle_arb_enable", 32'(arb_enable_o), 32'(0));
        chk("group_no_perr", 32'(protocol_err_o), 32'(0));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_req"}, 32'(req_o), 32'(0));
        chk({nm, "_arb_enable"}, 32'(arb_enable_o), 32'(0));
        chk({nm, "_arb_clear"}, 32'(arb_clear_o), 32'(0));
        chk({nm, "_valid"}, 32'(evt_valid_o), 32'(0));
        chk({nm, "_row"}, 32'(evt_row_o), 32'(0));
        chk({nm, "_ts"}, 32'(evt_ts_o), 32'(0));
        chk({nm, "_overflow"}, 32'(overflow_o), 32'(0));
        chk({nm, "_perr"}, 32'(protocol_err_o), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TSW-1:0] c0;
        bit             seen;
        int             hs0;

        vecs[0] = '{evt: 4'b0100, stall: 0, exp_req: 4'b0100, n_events: 1};
        vecs[1] = '{evt: 4'b1011, stall: 0, exp_req: 4'b1011, n_events: 3};
        vecs[2] = '{evt: 4'b1011, stall: 5, exp_req: 4'b1011, n_events: 3};
        vecs[3] = '{evt: 4'b1111, stall: 0, exp_req: 4'b1111, n_events: 4};
        vecs[4] = '{evt: 4'b0110, stall: 2, exp_req: 4'b0110, n_events: 2};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_i = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) run_group(vecs[t]);

        // Overflow: the same row fires twice while its first event is already pending.
        hs0 = hs_cnt;
        c0  = cyc;
        q.push_back('{row: 2'd0, ts: c0});
        q.push_back('{row: 2'd0, ts: 16'(c0 + 16'd6)});
        evt = 4'b0001;
        @(posedge clk); #1;
        chk("ovf_capture", 32'(overflow_o), 32'(0));
        @(posedge clk); #1;
        chk("ovf_first_pending", 32'(overflow_o), 32'(0));
        @(posedge clk); #1;
        chk("ovf_pulse", 32'(overflow_o), 32'(1));
        evt = '0;
        @(posedge clk); #1;
        chk("ovf_pulse_end", 32'(overflow_o), 32'(0));
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (req_o != '0) seen = 1;
        end
        chk("ovf_next_group_seen", 32'(seen), 32'(1));
        chk("ovf_next_group_req", 32'(req_o), 32'(4'b0001));
        wait_group_end("ovf_group");
        chk("ovf_event_count", 32'(hs_cnt - hs0), 32'(2));
        chk("ovf_queue_empty", 32'(q.size()), 32'(0));

        // Held duplicate grant for an already-served row: ignored, no error.
        hs0       = hs_cnt;
        arb_hold  = 1'b1;
        force_en  = 1'b1;
        force_gnt = '0;
        q.push_back('{row: 2'd0, ts: cyc});
        q.push_back('{row: 2'd1, ts: cyc});
        evt = 4'b0011;
        @(posedge clk); #1;
        evt       = '0;
        force_gnt = 4'b0001;
        @(posedge clk); #1;
        chk("dup_first_valid", 32'(evt_valid_o), 32'(1));
        @(posedge clk); #1;
        chk("dup_no_reload", 32'(evt_valid_o), 32'(0));
        chk("dup_req", 32'(req_o), 32'(4'b0010));
        chk("dup_no_perr", 32'(protocol_err_o), 32'(0));
        @(posedge clk); #1;
        chk("dup_no_reload2", 32'(evt_valid_o), 32'(0));
        force_gnt = 4'b0010;
        @(posedge clk); #1;
        force_en = 1'b0;
        arb_hold = 1'b0;
        wait_group_end("dup_group");
        chk("dup_event_count", 32'(hs_cnt - hs0), 32'(2));
        chk("dup_perr_end", 32'(protocol_err_o), 32'(0));

        // One-hot grant for a row never requested in this group.
        arb_hold = 1'b1;
        q.push_back('{row: 2'd0, ts: cyc});
        evt = 4'b0001;
        @(posedge clk); #1;
        evt = '0;
        chk("perr_a_before", 32'(protocol_err_o), 32'(0));
        force_en  = 1'b1;
        force_gnt = 4'b1000;
        @(posedge clk); #1;
        chk("perr_a_set", 32'(protocol_err_o), 32'(1));
        chk("perr_a_no_event", 32'(evt_valid_o), 32'(0));
        chk("perr_a_req", 32'(req_o), 32'(4'b0001));
        force_en = 1'b0;
        arb_hold = 1'b0;
        wait_group_end("perr_a_group");
        chk("perr_a_sticky", 32'(protocol_err_o), 32'(1));
        chk("perr_a_queue_empty", 32'(q.size()), 32'(0));

        // Reset while an event is held on the output.
        ready = 1'b0;
        q.push_back('{row: 2'd0, ts: cyc});
        q.push_back('{row: 2'd1, ts: cyc});
        evt = 4'b0011;
        @(posedge clk); #1;
        evt  = '0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            if (evt_valid_o) seen = 1;
        end
        chk("rst_mid_valid_seen", 32'(seen), 32'(1));
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        q.delete();
        ready = 1'b1;
        check_reset_outputs("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_quiet_valid", 32'(evt_valid_o), 32'(0));
            chk("rst_quiet_req", 32'(req_o), 32'(0));
        end
        hs0 = hs_cnt;
        q.push_back('{row: 2'd3, ts: 16'd3});
        evt = 4'b1000;
        @(posedge clk); #1;
        evt = '0;
        wait_group_end("rst_group");
        chk("rst_event_count", 32'(hs_cnt - hs0), 32'(1));

        // Non-one-hot grant, then a foreign one-hot grant.
        arb_hold = 1'b1;
        q.push_back('{row: 2'd0, ts: cyc});
        evt = 4'b0001;
        @(posedge clk); #1;
        evt       = '0;
        force_en  = 1'b1;
        force_gnt = 4'b0110;
        @(posedge clk); #1;
        chk("perr_b_set", 32'(protocol_err_o), 32'(1));
        chk("perr_b_no_event", 32'(evt_valid_o), 32'(0));
        force_gnt = 4'b1000;
        @(posedge clk); #1;
        chk("perr_b_no_event2", 32'(evt_valid_o), 32'(0));
        chk("perr_b_req", 32'(req_o), 32'(4'b0001));
        force_en = 1'b0;
        arb_hold = 1'b0;
        wait_group_end("perr_b_group");
        chk("perr_b_sticky", 32'(protocol_err_o), 32'(1));
        chk("perr_b_queue_empty", 32'(q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
